// File: rtl/dac_player_if.sv
// rtl/dac_player_if.sv - control, SRAM data and CODEC serial signals of dac_player
interface dac_player_if #(
  parameter int AW = 18,
  parameter int DW = 16
) ();
  logic          daclrc;
  logic          play_start;
  logic          pause;
  logic          stop;
  logic [3:0]    speed;
  logic [AW-1:0] end_addr;
  logic [DW-1:0] sram_dq;
  logic          oe_n;
  logic          dacdat;
  logic          busy;
  logic          done;

  modport master (
    output daclrc, play_start, pause, stop, speed, end_addr, sram_dq,
    input  oe_n, dacdat, busy, done
  );

  modport slave (
    input  daclrc, play_start, pause, stop, speed, end_addr, sram_dq,
    output oe_n, dacdat, busy, done
  );
endinterface

// File: rtl/dac_player.sv
// rtl/dac_player.sv - SRAM sample playback to CODEC DACDAT with pause/stop/fast/slow
module dac_player #(
  parameter int AW = 18,
  parameter int DW = 16
) (
  input  logic          bclk,
  input  logic          rst_n,
  dac_player_if.slave   bus,
  output logic [AW-1:0] addr
);
  localparam int CW = $clog2(DW + 1);

  typedef enum logic [2:0] {S_IDLE, S_PRIME, S_PLAY, S_PAUSE, S_LAST} state_t;

  state_t        state, state_nxt;
  logic [1:0]    lrc_h;
  logic [AW-1:0] addr_buf;
  logic [DW-1:0] cur_sample, next_sample, shift;
  logic [CW-1:0] bit_cnt;
  logic [2:0]    rep_cnt;
  logic          dacdat_q, done_q;

  logic          fall, rise, rep_hold, at_last;
  logic [3:0]    n_fac;
  logic [AW:0]   adv_sum;
  logic          ld_start, do_adv, rep_inc, fetch, done_nxt;
  logic [DW-1:0] word;

  assign fall     = (lrc_h == 2'b10);
  assign rise     = (lrc_h == 2'b01);
  assign n_fac    = {1'b0, bus.speed[2:0]} + 4'd1;
  // one extra bit so a step past the top of the address space cannot wrap
  assign adv_sum  = {1'b0, addr_buf} + (bus.speed[3] ? (AW+1)'(1) : (AW+1)'(n_fac));
  assign at_last  = (adv_sum > {1'b0, bus.end_addr});
  assign rep_hold = bus.speed[3] && ({1'b0, rep_cnt} < (n_fac - 4'd1));

  always_ff @(posedge bclk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    ld_start  = 1'b0;
    do_adv    = 1'b0;
    rep_inc   = 1'b0;
    fetch     = 1'b0;
    done_nxt  = 1'b0;
    word      = '0;
    case (state)
      S_IDLE: begin
        if (bus.play_start && (bus.end_addr != '0)) begin
          state_nxt = S_PRIME;
          ld_start  = 1'b1;
        end
      end
      S_PRIME: begin
        if (rise) begin
          fetch     = 1'b1;
          state_nxt = S_PLAY;
        end
      end
      S_PLAY, S_PAUSE: begin
        if (fall) begin
          if (bus.pause) begin
            state_nxt = S_PAUSE;
          end else begin
            state_nxt = S_PLAY;
            word      = next_sample;
            if (rep_hold)     rep_inc   = 1'b1;
            else if (at_last) state_nxt = S_LAST;
            else              do_adv    = 1'b1;
          end
        end else if (rise && (state == S_PLAY)) begin
          fetch = 1'b1;
          word  = cur_sample;
        end
      end
      S_LAST: begin
        if (fall) begin
          state_nxt = S_IDLE;
          done_nxt  = 1'b1;
        end else if (rise) begin
          word = cur_sample;
        end
      end
      default: state_nxt = S_IDLE;
    endcase
    if (bus.stop) begin
      state_nxt = S_IDLE;
      ld_start  = 1'b0;
      do_adv    = 1'b0;
      rep_inc   = 1'b0;
      fetch     = 1'b0;
      done_nxt  = 1'b0;
    end
  end

  always_ff @(posedge bclk or negedge rst_n) begin
    if (!rst_n) begin
      lrc_h       <= 2'b00;
      addr_buf    <= '0;
      rep_cnt     <= '0;
      cur_sample  <= '0;
      next_sample <= '0;
      shift       <= '0;
      bit_cnt     <= '0;
      dacdat_q    <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      lrc_h  <= {lrc_h[0], bus.daclrc};
      done_q <= done_nxt;
      if (ld_start) begin
        addr_buf <= AW'(1);
        rep_cnt  <= '0;
      end else if (do_adv) begin
        addr_buf <= adv_sum[AW-1:0];
        rep_cnt  <= '0;
      end else if (rep_inc) begin
        rep_cnt <= rep_cnt + 3'd1;
      end
      if (fetch) next_sample <= bus.sram_dq;
      if (fall)  cur_sample  <= next_sample;
      // bit 0 leaves on the slot edge itself, the rest follow one per bclk
      if (bus.stop) begin
        dacdat_q <= 1'b0;
        shift    <= '0;
        bit_cnt  <= '0;
      end else if (fall || rise) begin
        dacdat_q <= word[0];
        shift    <= word >> 1;
        bit_cnt  <= CW'(DW - 1);
      end else if (bit_cnt != '0) begin
        dacdat_q <= shift[0];
        shift    <= shift >> 1;
        bit_cnt  <= bit_cnt - CW'(1);
      end else begin
        dacdat_q <= 1'b0;
      end
    end
  end

  assign bus.busy   = (state != S_IDLE);
  assign bus.oe_n   = (state == S_IDLE);
  assign bus.dacdat = dacdat_q;
  assign bus.done   = done_q;
  assign addr       = bus.busy ? addr_buf : {AW{1'bz}};
endmodule

// File: tb/tb_dac_player.sv
// tb/tb_dac_player.sv - randomized frame-level model check of dac_player
module tb_dac_player;
  localparam int AW = 18;
  localparam int DW = 16;

  logic          bclk = 1'b0;
  logic          rst_n = 1'b0;
  wire  [AW-1:0] addr;

  dac_player_if #(.AW(AW), .DW(DW)) bus ();

  dac_player #(.AW(AW), .DW(DW)) dut (
    .bclk (bclk),
    .rst_n(rst_n),
    .bus  (bus.slave),
    .addr (addr)
  );

  always #5 bclk = ~bclk;

  logic [15:0] mem [0:63];
  assign bus.sram_dq = mem[addr[5:0]];

  int   total = 0;
  int   bad = 0;
  int   done_seen = 0;
  bit   chk_en = 1'b0;
  logic exp_dat = 1'b0, exp_busy = 1'b0, exp_done = 1'b0;
  int   hl = 20;
  bit   pz [0:255];
  int   seq [$];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s t=%0t act=%0h exp=%0h", nm, $time, act, exp);
    end
  endtask

  always @(negedge bclk) begin
    if (chk_en) begin
      chk("dacdat", 32'(bus.dacdat), 32'(exp_dat));
      chk("busy", 32'(bus.busy), 32'(exp_busy));
      chk("oe_n", 32'(bus.oe_n), 32'(!exp_busy));
      chk("done", 32'(bus.done), 32'(exp_done));
      if (exp_busy && bus.busy)
        chk("addr_range", 32'(addr >= AW'(1) && addr <= bus.end_addr), 32'd1);
      if (bus.done) done_seen++;
    end
  end

  // Addresses played, one entry per non-silent frame.
  function automatic void build_seq(input logic [3:0] spd, input int ea);
    int n;
    n = int'(spd[2:0]) + 1;
    seq.delete();
    if (spd[3]) begin
      for (int a = 1; a <= ea; a++)
        for (int r = 0; r < n; r++) seq.push_back(a);
    end else begin
      for (int a = 1; a <= ea; a += n) seq.push_back(a);
    end
  endfunction

  task automatic step();
    @(posedge bclk);
    #2;
  endtask

  // One daclrc frame; expectations for step j describe outputs after that posedge.
  // kind: 0 none, 1 play_start, 2 stop, 3 both, issued at step act_j.
  task automatic frame(input logic [15:0] l, input logic [15:0] r, input bit bprev,
                       input bit bnew, input int bchg, input bit dn, input int act_j,
                       input int kind, input bit pz_nxt);
    for (int j = 0; j < 2 * hl; j++) begin
      step();
      if (j == 0) bus.daclrc = 1'b0;
      if (j == hl) bus.daclrc = 1'b1;
      if (j == hl + 5) bus.pause = pz_nxt;
      if (kind != 0 && j == act_j) begin
        bus.play_start = (kind != 2);
        bus.stop       = (kind >= 2);
      end
      if (kind != 0 && j == act_j + 1) begin
        bus.play_start = 1'b0;
        bus.stop       = 1'b0;
      end
      if (kind == 2 && j > act_j)              exp_dat = 1'b0;
      else if (j >= 2 && j <= 17)              exp_dat = l[4'(j - 2)];
      else if (j >= hl + 2 && j <= hl + 17)    exp_dat = r[4'(j - hl - 2)];
      else                                     exp_dat = 1'b0;
      exp_busy = (j >= bchg) ? bnew : bprev;
      exp_done = dn && (j == 2);
    end
  endtask

  task automatic run_play(input logic [3:0] spd, input int ea, input int stop_f,
                          input int stop_j, input int exp_dn);
    logic [15:0] w;
    int          i, d0;
    bit          p;
    d0 = done_seen;
    build_seq(spd, ea);
    hl = $urandom_range(18, 24);
    bus.speed    = spd;
    bus.end_addr = AW'(ea);
    frame(16'h0, 16'h0, 1'b0, 1'b1, 5, 1'b0, 4, 1, pz[0]);
    i = 0;
    for (int f = 0; f < 250; f++) begin
      if (i >= seq.size()) begin
        frame(16'h0, 16'h0, 1'b1, 1'b0, 2, 1'b1, 0, 0, 1'b0);
        break;
      end
      p = pz[f];
      w = p ? 16'h0 : mem[6'(seq[i])];
      if (!p) i++;
      if (f == stop_f) begin
        frame(w, w, 1'b1, 1'b0, stop_j + 1, 1'b0, stop_j, 2, 1'b0);
        break;
      end
      frame(w, w, 1'b1, 1'b1, 2, 1'b0, 0, 0, pz[f + 1]);
    end
    bus.pause = 1'b0;
    frame(16'h0, 16'h0, 1'b0, 1'b0, 2, 1'b0, 0, 0, 1'b0);
    chk("done_count", 32'(done_seen - d0), 32'(exp_dn));
    for (int k = 0; k < 256; k++) pz[k] = 1'b0;
  endtask

  initial begin
    bus.daclrc = 1'b1;
    bus.play_start = 1'b0;
    bus.pause = 1'b0;
    bus.stop = 1'b0;
    bus.speed = 4'd0;
    bus.end_addr = '0;
    for (int k = 0; k < 64; k++) mem[k] = 16'($urandom);
    for (int k = 0; k < 256; k++) pz[k] = 1'b0;
    repeat (3) @(posedge bclk);
    #2;
    chk("rst_dacdat", 32'(bus.dacdat), 32'd0);
    chk("rst_busy", 32'(bus.busy), 32'd0);
    chk("rst_oe_n", 32'(bus.oe_n), 32'd1);
    chk("rst_done", 32'(bus.done), 32'd0);
    rst_n = 1'b1;
    chk_en = 1'b1;
    frame(16'h0, 16'h0, 1'b0, 1'b0, 2, 1'b0, 0, 0, 1'b0);

    // basic playback, LSB first in both slots
    mem[1] = 16'h0001; mem[2] = 16'h8000; mem[3] = 16'hA5A5; mem[4] = 16'hFFFF;
    run_play(4'b0000, 4, -1, 0, 1);

    // fast x2 and slow x3 address patterns
    build_seq(4'b0001, 7);
    chk("seq_fast_len", 32'(seq.size()), 32'd4);
    chk("seq_fast_last", 32'(seq[3]), 32'd7);
    run_play(4'b0001, 7, -1, 0, 1);
    build_seq(4'b1010, 2);
    chk("seq_slow_len", 32'(seq.size()), 32'd6);
    chk("seq_slow_2", 32'(seq[2]), 32'd1);
    chk("seq_slow_3", 32'(seq[3]), 32'd2);
    run_play(4'b1010, 2, -1, 0, 1);

    // pause held over two frame starts
    pz[2] = 1'b1; pz[3] = 1'b1;
    run_play(4'b0000, 6, -1, 0, 1);

    // stop at bit 7 of the second frame, then a fresh start
    run_play(4'b0000, 6, 1, 8, 0);
    run_play(4'b0000, 3, -1, 0, 1);

    // ignored starts
    hl = 20;
    bus.end_addr = '0;
    frame(16'h0, 16'h0, 1'b0, 1'b0, 2, 1'b0, 4, 1, 1'b0);
    bus.end_addr = AW'(4);
    frame(16'h0, 16'h0, 1'b0, 1'b0, 2, 1'b0, 4, 3, 1'b0);
    frame(16'h0, 16'h0, 1'b0, 1'b0, 2, 1'b0, 0, 0, 1'b0);

    // asynchronous reset while a 1 bit is on dacdat
    for (int k = 1; k <= 3; k++) mem[k] = 16'hFFFF;
    bus.speed = 4'd0;
    bus.end_addr = AW'(3);
    frame(16'h0, 16'h0, 1'b0, 1'b1, 5, 1'b0, 4, 1, 1'b0);
    for (int j = 0; j < 8; j++) begin
      step();
      if (j == 0) bus.daclrc = 1'b0;
      exp_dat = (j >= 2);
      exp_busy = 1'b1;
      exp_done = 1'b0;
    end
    #4;
    chk_en = 1'b0;
    chk("pre_rst_dat", 32'(bus.dacdat), 32'd1);
    rst_n = 1'b0;
    #1;
    chk("arst_dacdat", 32'(bus.dacdat), 32'd0);
    chk("arst_busy", 32'(bus.busy), 32'd0);
    chk("arst_oe_n", 32'(bus.oe_n), 32'd1);
    chk("arst_done", 32'(bus.done), 32'd0);
    repeat (2) step();
    rst_n = 1'b1;
    exp_dat = 1'b0;
    exp_busy = 1'b0;
    exp_done = 1'b0;
    chk_en = 1'b1;
    frame(16'h0, 16'h0, 1'b0, 1'b0, 2, 1'b0, 0, 0, 1'b0);

    // randomized runs
    for (int t = 0; t < 6; t++) begin
      logic [3:0] spd;
      int         ea;
      for (int k = 1; k < 64; k++) mem[k] = 16'($urandom);
      spd = 4'($urandom_range(0, 15));
      ea  = spd[3] ? $urandom_range(1, 4) : $urandom_range(1, 20);
      for (int k = 0; k < 250; k++) pz[k] = ($urandom_range(0, 3) == 0);
      run_play(spd, ea, -1, 0, 1);
    end

    chk_en = 1'b0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
